leaf_tx_queue: RTL
==================

Name: leaf_tx_queue

Overview:
- Transmit-side stage between a leaf PE and its ring bus interface.
- Buffers outgoing packets from the PE and presents the head packet on the interface's PE-input port.
- Holds and re-presents the head packet for every cycle the interface signals resend, which happens while the bus is forwarding transit traffic.
- Packet format: {valid(1), dest($clog2(num_leaves)), payload(payload_sz)}, MSB first.

Parameters:
- num_leaves, 2: number of leaves on the bus; sets the dest field width.
- payload_sz, 1: payload width in bits.
- depth, 4: queue entries; must be a power of 2 and at least 2.
- p_sz, 1 + $clog2(num_leaves) + payload_sz: packet width; derived, never overridden.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  PE offers a packet this cycle.
- in_ready  out  1  queue accepts; a push happens when in_valid && in_ready.
- in_dest  in  $clog2(num_leaves)  destination leaf address.
- in_payload  in  payload_sz  packet payload.
- resend  in  1  from the bus interface, combinational same-cycle; 1 means the presented packet was not taken.
- pe_interface  out  p_sz  packet offered to the bus interface; all-zero when the queue is empty.
- count  out  $clog2(depth)+1  current occupancy, 0..depth.
- stall_cnt  out  16  saturating count of cycles in which the head was presented and resend=1.

Behaviour:
- Reset (async assert, sync deassert by integration): pointers, count and stall_cnt clear to 0 immediately.
  - pe_interface = 0 and in_ready = 1 while in reset and after it.
  - Stored contents are discarded, including any packet mid-retry.
- Storage: depth-entry circular buffer with rd_ptr/wr_ptr, each $clog2(depth)+1 bits (extra wrap bit).
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
  - Pointers wrap modulo 2*depth.
- Push: in_valid && !full writes {1'b1, in_dest, in_payload} at wr_ptr and increments wr_ptr. in_ready = !full, combinational from state only, never from in_valid.
- Output: pe_interface = entry[rd_ptr] when !empty, else all-zero (valid bit 0).
  - Comes from registered state only; no combinational path from in_* to pe_interface.
  - Push-to-present latency: 1 cycle. A packet pushed at edge N appears after edge N if it is the new head.
- Pop: !empty && !resend at the clock edge increments rd_ptr. This is the same edge at which the bus interface registers pe_interface onto the bus.
- Retry: !empty && resend leaves rd_ptr unchanged, holds pe_interface stable, and increments stall_cnt, saturating at 16'hFFFF.
- resend while empty: ignored; no pop and no stall count.
- Simultaneous push and pop, not full: both happen; count unchanged.
  - Empty queue: push only; the new packet is not bypassed to the output in the same cycle.
  - Full queue: in_ready = 0, so no push. A pop this cycle makes in_ready = 1 on the next cycle; there is no same-cycle refill.
- count = wr_ptr - rd_ptr, taken modulo 2*depth.
- Ordering: strict FIFO; no reordering by destination.
- Pushing a packet addressed to the leaf's own address is legal; the queue does not inspect dest.
- The bus interface uses an active-high synchronous reset. The integration wrapper drives it from !reset_n through a reset synchroniser; this block does not do that conversion.

Decomposition:
- Shared package leaf_bus_pkg holds:
  - function pkt_width(num_leaves, payload_sz)
  - localparams for field positions: VALID_BIT = p_sz-1, DEST_HI = p_sz-2, DEST_LO = payload_sz
  - helper pkt_pack(dest, payload)
- The bus interface and this block both use the package.
- One sub-module, leaf_tx_fifo: the parameterised circular buffer with push/pop/empty/full/count.
- leaf_tx_queue adds packet packing, the resend-driven pop and the stall counter.

Test Plan (num_leaves=4, payload_sz=8, depth=4, p_sz=11):
- Reset then idle -> pe_interface=11'h000, in_ready=1, count=0, stall_cnt=0.
- Push dest=2, payload=8'hA5 with resend=0 -> next cycle pe_interface=11'h6A5; popped at the following edge; count returns to 0.
- Push dest=1, payload=8'h3C, then hold resend=1 for 3 cycles -> pe_interface stays 11'h53C for 3 cycles, stall_cnt=3; pops on the first cycle with resend=0.
- Push 5 packets back-to-back with resend=1 -> first 4 accepted, in_ready=0 on the 5th, count=4. Release resend -> packets drain in push order, one per cycle, and in_ready returns to 1 after the first pop.
- Steady push and pop each cycle with resend=0 -> count stays 1, 8 packets emerge in order, and pointers wrap cleanly.
- Assert reset_n=0 mid-cycle with 3 packets queued and resend=1 -> pe_interface=0 immediately (asynchronously); count=0 and stall_cnt=0 after release.

Source files
------------

// File: rtl/leaf_bus_pkg.sv
// Shared packet-format helpers for the leaf ring bus: width and field positions of
// {valid, dest, payload} packets, plus a generic packer for up to 64-bit packets.
package leaf_bus_pkg;

  localparam int PKT_MAX_W = 64;

  function automatic int pkt_width(input int num_leaves, input int payload_sz);
    return 1 + $clog2(num_leaves) + payload_sz;
  endfunction

  function automatic int pkt_valid_bit(input int p_sz);
    return p_sz - 1;
  endfunction

  function automatic int pkt_dest_hi(input int p_sz);
    return p_sz - 2;
  endfunction

  function automatic int pkt_dest_lo(input int payload_sz);
    return payload_sz;
  endfunction

  // Oversized result; callers keep the low pkt_width() bits.
  function automatic logic [PKT_MAX_W-1:0] pkt_pack(
    input int                   dest_w,
    input int                   payload_sz,
    input logic [PKT_MAX_W-1:0] dest,
    input logic [PKT_MAX_W-1:0] payload
  );
    logic [PKT_MAX_W-1:0] dest_mask;
    logic [PKT_MAX_W-1:0] payload_mask;
    dest_mask    = (64'd1 << dest_w) - 64'd1;
    payload_mask = (64'd1 << payload_sz) - 64'd1;
    return (64'd1 << (dest_w + payload_sz))
         | ((dest & dest_mask) << payload_sz)
         | (payload & payload_mask);
  endfunction

endpackage

// File: rtl/leaf_tx_fifo.sv
// Circular buffer with wrap-bit pointers; push/pop are gated internally by full/empty,
// so callers may assert them unconditionally.
module leaf_tx_fifo #(
  parameter int width = 11,
  parameter int depth = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [width-1:0]       wr_data,
  output logic [width-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(depth):0] count
);

  localparam int IDX_W = $clog2(depth);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [width-1:0] mem_reg [depth];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]) &&
                   (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  // Pointer difference wraps modulo 2*depth, which yields 0..depth directly.
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign rd_data = mem_reg[rd_ptr_reg[IDX_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Contents need no reset: an entry is only visible between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg[IDX_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/leaf_tx_queue.sv
// Transmit queue between a leaf PE and its ring bus interface: packs PE packets,
// presents the head until the interface stops asking for a resend, counts stalls.
module leaf_tx_queue
  import leaf_bus_pkg::*;
#(
  parameter  int num_leaves = 2,
  parameter  int payload_sz = 1,
  parameter  int depth      = 4,
  localparam int p_sz       = pkt_width(num_leaves, payload_sz)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(num_leaves)-1:0] in_dest,
  input  logic [payload_sz-1:0]         in_payload,
  input  logic                          resend,
  output logic [p_sz-1:0]               pe_interface,
  output logic [$clog2(depth):0]        count,
  output logic [15:0]                   stall_cnt
);

  localparam int VALID_BIT = pkt_valid_bit(p_sz);
  localparam int DEST_HI   = pkt_dest_hi(p_sz);
  localparam int DEST_LO   = pkt_dest_lo(payload_sz);

  logic [p_sz-1:0] pkt_in;
  logic [p_sz-1:0] head_pkt;
  logic            empty;
  logic            full;
  logic [15:0]     stall_cnt_reg;
  logic [15:0]     stall_cnt_next;

  always_comb begin
    pkt_in                  = '0;
    pkt_in[VALID_BIT]       = 1'b1;
    pkt_in[DEST_HI:DEST_LO] = in_dest;
    pkt_in[DEST_LO-1:0]     = in_payload;
  end

  // The bus interface samples pe_interface at the same edge a pop happens, so
  // !resend is exactly "the head was taken".
  leaf_tx_fifo #(
    .width (p_sz),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (in_valid),
    .pop     (!resend),
    .wr_data (pkt_in),
    .rd_data (head_pkt),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  assign in_ready     = !full;
  assign pe_interface = empty ? '0 : head_pkt;

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (!empty && resend && (stall_cnt_reg != 16'hFFFF))
      stall_cnt_next = stall_cnt_reg + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt_reg <= '0;
    else          stall_cnt_reg <= stall_cnt_next;
  end

  assign stall_cnt = stall_cnt_reg;

endmodule
